// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between fetch and data.
// One access every three cycles: accept in IDLE, drive memory in ISSUE, respond in WAIT.
module mem_arbiter #(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  input  logic          d_req,
  input  logic [AW-1:0] d_addr,
  input  logic          d_we,
  input  logic [31:0]   d_wdata,
  output logic          f_gnt,
  output logic          d_gnt,
  output logic          f_rvalid,
  output logic          d_rvalid,
  output logic [31:0]   rdata,
  output logic          err,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-3:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_q, last_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          we_q, we_d;
  logic [31:0]   wdata_q, wdata_d;

  logic in_issue;
  logic in_wait;
  logic mis;
  logic live;

  // owner/last: 0 = fetch port, 1 = data port
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (f_req || d_req) begin
          owner_d = d_req && (!f_req || !last_q);
          last_d  = owner_d;
          addr_d  = owner_d ? d_addr : f_addr;
          we_d    = owner_d && d_we;
          wdata_d = owner_d ? d_wdata : '0;
          state_d = ISSUE;
        end
      end
      ISSUE:   state_d = WAIT;
      WAIT:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
    end
  end

  assign in_issue = (state_q == ISSUE);
  assign in_wait  = (state_q == WAIT);
  assign mis      = |addr_q[1:0];
  // a reset during WAIT swallows the response
  assign live     = in_wait && rst_n;

  assign f_gnt     = in_issue && !owner_q;
  assign d_gnt     = in_issue && owner_q;
  assign mem_en    = in_issue && !mis;
  assign mem_we    = mem_en && we_q;
  assign mem_addr  = mem_en ? addr_q[AW-1:2] : '0;
  assign mem_wdata = mem_en ? wdata_q : '0;

  assign f_rvalid = live && !owner_q;
  assign d_rvalid = live && owner_q;
  assign err      = live && mis;
  assign rdata    = (live && !mis && !we_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, then random traffic
// against a transaction-level reference model with its own memory image.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        f_req, d_req, d_we;
  logic [31:0] f_addr, d_addr, d_wdata;
  logic        f_gnt, d_gnt, f_rvalid, d_rvalid, err;
  logic [31:0] rdata;
  logic        mem_en, mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .f_req(f_req), .f_addr(f_addr),
    .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata),
    .f_gnt(f_gnt), .d_gnt(d_gnt),
    .f_rvalid(f_rvalid), .d_rvalid(d_rvalid),
    .rdata(rdata), .err(err),
    .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr[7:0]];
    end
  end

  typedef struct packed {
    logic        fg, dg, fv, dv, er, en, we;
    logic [29:0] ma;
    logic [31:0] wd, rd;
  } out_t;

  typedef struct packed {
    logic        rs, f, d, w;
    logic [31:0] fa, da, wdi;
    out_t        o;
  } vec_t;

  int n_chk = 0;
  int n_fail = 0;

  function automatic logic [31:0] init_word(input int i);
    logic [31:0] v;
    v = i * 32'h0101_0101;
    return v ^ 32'hC3C3_0000;
  endfunction

  function automatic vec_t V(
    input logic rs, f, d, w,
    input logic [31:0] fa, da, wdi,
    input logic fg, dg, fv, dv, er, en, mw,
    input logic [29:0] ma,
    input logic [31:0] mwd, rd);
    vec_t v;
    v.rs = rs; v.f = f; v.d = d; v.w = w;
    v.fa = fa; v.da = da; v.wdi = wdi;
    v.o.fg = fg; v.o.dg = dg; v.o.fv = fv; v.o.dv = dv;
    v.o.er = er; v.o.en = en; v.o.we = mw;
    v.o.ma = ma; v.o.wd = mwd; v.o.rd = rd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic cmp(input string tag, input out_t e);
    logic issue;
    issue = e.fg | e.dg;
    chk({tag, " f_gnt"}, f_gnt, e.fg);
    chk({tag, " d_gnt"}, d_gnt, e.dg);
    chk({tag, " f_rvalid"}, f_rvalid, e.fv);
    chk({tag, " d_rvalid"}, d_rvalid, e.dv);
    chk({tag, " err"}, err, e.er);
    chk({tag, " rdata"}, rdata, e.rd);
    chk({tag, " mem_en"}, mem_en, e.en);
    chk({tag, " mem_we"}, mem_we, e.we);
    if (e.en || !issue) chk({tag, " mem_addr"}, mem_addr, e.ma);
    if (e.we || !issue) chk({tag, " mem_wdata"}, mem_wdata, e.wd);
    chk("inv gnt_onehot", f_gnt & d_gnt, 0);
    chk("inv rvalid_onehot", f_rvalid & d_rvalid, 0);
    chk("inv err_needs_rvalid", err & ~(f_rvalid | d_rvalid), 0);
    if (!(f_gnt | d_gnt))
      chk("inv mem_quiet", {mem_en, mem_we, |mem_addr, |mem_wdata}, 0);
  endtask

  // Reference model: one outstanding transaction, accepted at cycle tt,
  // granted at tt+1 and answered at tt+2; arbiter free otherwise.
  int          cyc = 0;
  bit          tv = 0;
  int          tt = 0;
  bit          town, tlast = 0, twe, tmis;
  logic [31:0] taddr, twdata, trd;

  function automatic out_t model_exp();
    out_t o;
    o = '0;
    if (tv && cyc == tt + 1) begin
      o.fg = !town;
      o.dg = town;
      o.en = !tmis;
      o.we = !tmis && twe;
      o.ma = tmis ? 30'd0 : taddr[31:2];
      o.wd = (twe && !tmis) ? twdata : 32'd0;
    end else if (tv && cyc == tt + 2 && rst_n) begin
      o.fv = !town;
      o.dv = town;
      o.er = tmis;
      o.rd = (tmis || twe) ? 32'd0 : trd;
    end
    return o;
  endfunction

  task automatic model_update();
    bit busy;
    if (tv && cyc == tt + 1) begin
      trd = ref_mem[taddr[9:2]];
      if (twe && !tmis) ref_mem[taddr[9:2]] = twdata;
    end
    busy = tv && (cyc == tt + 1 || cyc == tt + 2);
    if (!rst_n) begin
      tv = 0;
      tlast = 0;
    end else if (!busy && (f_req || d_req)) begin
      if (f_req && d_req) town = (tlast == 0);
      else                town = d_req;
      tlast  = town;
      tv     = 1;
      tt     = cyc;
      taddr  = town ? d_addr : f_addr;
      twe    = town && d_we;
      twdata = d_wdata;
      tmis   = taddr[1:0] != 2'b00;
    end
    cyc++;
  endtask

  function automatic logic [31:0] rnd_addr();
    logic [31:0] a;
    a = $urandom_range(0, 255) * 4;
    if ($urandom_range(0, 7) == 0) a = a + $urandom_range(1, 3);
    return a;
  endfunction

  vec_t tbl [37];

  initial begin
    logic [31:0] w12, w16;
    for (int i = 0; i < 256; i++) begin
      mem[i] = init_word(i);
      ref_mem[i] = init_word(i);
    end
    mem[4] = 32'hDEAD_BEEF;
    ref_mem[4] = 32'hDEAD_BEEF;
    w12 = init_word(12);
    w16 = init_word(16);
    mem_rdata = '0;

    tbl[0]  = V(1,1,0,0,'h10,0,0,       0,0,0,0,0,0,0, 0,0,0);
    tbl[1]  = V(1,0,0,0,0,0,0,          1,0,0,0,0,1,0, 4,0,0);
    tbl[2]  = V(1,0,0,0,0,0,0,          0,0,1,0,0,0,0, 0,0,'hDEADBEEF);
    tbl[3]  = V(0,0,0,0,0,0,0,          0,0,0,0,0,0,0, 0,0,0);
    tbl[4]  = V(1,1,1,0,'h10,'h30,0,    0,0,0,0,0,0,0, 0,0,0);
    tbl[5]  = V(1,1,1,0,'h10,'h30,0,    0,1,0,0,0,1,0, 12,0,0);
    tbl[6]  = V(1,1,1,0,'h10,'h30,0,    0,0,0,1,0,0,0, 0,0,w12);
    tbl[7]  = V(1,1,1,0,'h10,'h30,0,    0,0,0,0,0,0,0, 0,0,0);
    tbl[8]  = V(1,1,1,0,'h10,'h30,0,    1,0,0,0,0,1,0, 4,0,0);
    tbl[9]  = V(1,1,1,0,'h10,'h30,0,    0,0,1,0,0,0,0, 0,0,'hDEADBEEF);
    tbl[10] = V(1,1,1,0,'h10,'h30,0,    0,0,0,0,0,0,0, 0,0,0);
    tbl[11] = V(1,1,1,0,'h10,'h30,0,    0,1,0,0,0,1,0, 12,0,0);
    tbl[12] = V(1,1,1,0,'h10,'h30,0,    0,0,0,1,0,0,0, 0,0,w12);
    tbl[13] = V(1,1,1,0,'h10,'h30,0,    0,0,0,0,0,0,0, 0,0,0);
    tbl[14] = V(1,0,0,0,0,0,0,          1,0,0,0,0,1,0, 4,0,0);
    tbl[15] = V(1,0,0,0,0,0,0,          0,0,1,0,0,0,0, 0,0,'hDEADBEEF);
    tbl[16] = V(1,0,1,1,0,'h20,'h12345678, 0,0,0,0,0,0,0, 0,0,0);
    tbl[17] = V(1,0,0,0,0,0,0,          0,1,0,0,0,1,1, 8,'h12345678,0);
    tbl[18] = V(1,0,0,0,0,0,0,          0,0,0,1,0,0,0, 0,0,0);
    tbl[19] = V(1,0,1,0,0,'h20,0,       0,0,0,0,0,0,0, 0,0,0);
    tbl[20] = V(1,0,0,0,0,0,0,          0,1,0,0,0,1,0, 8,0,0);
    tbl[21] = V(1,0,0,0,0,0,0,          0,0,0,1,0,0,0, 0,0,'h12345678);
    tbl[22] = V(1,0,1,0,0,'h22,0,       0,0,0,0,0,0,0, 0,0,0);
    tbl[23] = V(1,0,0,0,0,0,0,          0,1,0,0,0,0,0, 0,0,0);
    tbl[24] = V(1,0,0,0,0,0,0,          0,0,0,1,1,0,0, 0,0,0);
    tbl[25] = V(1,0,1,0,0,'h30,0,       0,0,0,0,0,0,0, 0,0,0);
    tbl[26] = V(1,0,0,0,0,0,0,          0,1,0,0,0,1,0, 12,0,0);
    tbl[27] = V(0,0,0,0,0,0,0,          0,0,0,0,0,0,0, 0,0,0);
    tbl[28] = V(1,1,1,0,'h10,'h30,0,    0,0,0,0,0,0,0, 0,0,0);
    tbl[29] = V(1,0,0,0,0,0,0,          0,1,0,0,0,1,0, 12,0,0);
    tbl[30] = V(1,0,0,0,0,0,0,          0,0,0,1,0,0,0, 0,0,w12);
    tbl[31] = V(0,0,1,1,0,'h40,'hAAAA5555, 0,0,0,0,0,0,0, 0,0,0);
    tbl[32] = V(1,0,0,0,0,0,0,          0,0,0,0,0,0,0, 0,0,0);
    tbl[33] = V(1,0,1,0,0,'h40,0,       0,0,0,0,0,0,0, 0,0,0);
    tbl[34] = V(1,0,0,0,0,0,0,          0,1,0,0,0,1,0, 16,0,0);
    tbl[35] = V(1,0,0,0,0,0,0,          0,0,0,1,0,0,0, 0,0,w16);
    tbl[36] = V(1,0,0,0,0,0,0,          0,0,0,0,0,0,0, 0,0,0);

    rst_n = 1'b0;
    f_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    f_addr = '0; d_addr = '0; d_wdata = '0;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 37; i++) begin
      rst_n   = tbl[i].rs;
      f_req   = tbl[i].f;
      d_req   = tbl[i].d;
      d_we    = tbl[i].w;
      f_addr  = tbl[i].fa;
      d_addr  = tbl[i].da;
      d_wdata = tbl[i].wdi;
      @(negedge clk);
      cmp($sformatf("vec%0d", i), tbl[i].o);
      @(posedge clk);
      model_update();
      #1;
    end

    for (int i = 0; i < 1500; i++) begin
      rst_n   = ($urandom_range(0, 39) != 0);
      f_req   = $urandom_range(0, 1) == 1;
      d_req   = $urandom_range(0, 1) == 1;
      d_we    = $urandom_range(0, 1) == 1;
      f_addr  = rnd_addr();
      d_addr  = rnd_addr();
      d_wdata = $urandom;
      @(negedge clk);
      cmp("rand", model_exp());
      @(posedge clk);
      model_update();
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
